// File: rtl/lsu_bus_controller.sv
// lsu_bus_controller: load/store sequencer between the core and the data bus.
// One registered req/ack transaction per access, with byte-lane steering of
// store data, lane selection plus sign/zero extension of load data, and
// detection of misaligned and timed-out accesses.
module lsu_bus_controller #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Counter value in the last BUS cycle before the access is abandoned.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  // Byte enables for the access size and the low address bits.
  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   calc_be = 4'b0001 << lo;
      2'b01:   calc_be = 4'b0011 << {lo[1], 1'b0};
      default: calc_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated into every lane the access may target.
  function automatic logic [31:0] rep_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   rep_wdata = {4{d[7:0]}};
      2'b01:   rep_wdata = {2{d[15:0]}};
      default: rep_wdata = d;
    endcase
  endfunction

  // Half accesses need an even address, word accesses a word-aligned one.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lo[0];
      default: is_misaligned = (lo != 2'b00);
    endcase
  endfunction

  // Pick the addressed lane out of the bus word and extend it to 32 bits.
  function automatic logic [31:0] fmt_load(input logic [1:0] size, input logic sign,
                                           input logic [1:0] lane, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lane, 3'b000} +: 8];
    h = d[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   fmt_load = {{24{sign & b[7]}}, b};
      2'b01:   fmt_load = {{16{sign & h[15]}}, h};
      default: fmt_load = d;
    endcase
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_cnt;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_rdata;
  logic        r_is_load;
  logic [1:0]  r_size;
  logic        r_sign;
  logic [1:0]  r_lane;
  logic        r_to_fault;

  logic        w_access;
  logic        w_is_write;
  logic        w_misaligned;
  logic        w_stall;
  logic        w_fault;
  logic        w_start;
  logic        w_ack_take;
  logic        w_timeout;

  // A simultaneous read and write request is handled as a write.
  assign w_access     = mem_read | mem_write;
  assign w_is_write   = mem_write;
  assign w_misaligned = is_misaligned(mem_size, addr[1:0]);

  // Next-state logic plus the combinational stall/fault strobes.
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_fault      = 1'b0;
    w_start      = 1'b0;
    w_ack_take   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          if (w_misaligned) begin
            w_fault = 1'b1;
          end else begin
            w_stall      = 1'b1;
            w_start      = 1'b1;
            w_next_state = ST_BUS;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BUS: begin
        w_stall = 1'b1;
        // Ack takes priority over an expiring counter.
        if (bus_ack) begin
          w_ack_take   = 1'b1;
          w_next_state = ST_DONE;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_BUS;
        end
      end
      ST_DONE: begin
        w_fault      = r_to_fault;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Timeout counter: cleared on issue, counts BUS cycles without ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (w_start) begin
      r_cnt <= 8'd0;
    end else if ((r_state == ST_BUS) && !w_ack_take && !w_timeout) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Bus request and payload: loaded on issue, held until the access ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_be    <= 4'd0;
      r_bus_wdata <= 32'd0;
    end else if (w_start) begin
      r_bus_req   <= 1'b1;
      r_bus_we    <= w_is_write;
      r_bus_addr  <= {addr[31:2], 2'b00};
      r_bus_be    <= calc_be(mem_size, addr[1:0]);
      r_bus_wdata <= rep_wdata(mem_size, wdata);
    end else if (w_ack_take || w_timeout) begin
      r_bus_req   <= 1'b0;
    end else begin
      r_bus_req   <= r_bus_req;
    end
  end

  // Access context kept for formatting the returned load data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_load <= 1'b0;
      r_size    <= 2'b00;
      r_sign    <= 1'b0;
      r_lane    <= 2'b00;
    end else if (w_start) begin
      r_is_load <= ~w_is_write;
      r_size    <= mem_size;
      r_sign    <= mem_sign;
      r_lane    <= addr[1:0];
    end else begin
      r_is_load <= r_is_load;
    end
  end

  // Load result: formatted bus data on ack, zero on timeout, else held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'd0;
    end else if (w_ack_take && r_is_load) begin
      r_rdata <= fmt_load(r_size, r_sign, r_lane, bus_rdata);
    end else if (w_timeout && r_is_load) begin
      r_rdata <= 32'd0;
    end else begin
      r_rdata <= r_rdata;
    end
  end

  // Remembers a timeout so the fault pulse lands in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_fault <= 1'b0;
    end else begin
      r_to_fault <= w_timeout;
    end
  end

  // stall and fault are gated by reset so they drop the moment rst_n falls.
  assign stall     = rst_n & w_stall;
  assign fault     = rst_n & w_fault;
  assign rdata     = r_rdata;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_lsu_bus_controller.sv
// Directed bench for lsu_bus_controller (TIMEOUT = 4). Inputs change on the
// falling edge; outputs are checked 1 ns later, away from the rising edge.
module tb_lsu_bus_controller;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int n_vec;
  int n_err;

  lsu_bus_controller #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_size  (mem_size),
    .mem_sign  (mem_sign),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rdata     (rdata),
    .fault     (fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge (middle of the next cycle).
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_acc(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd);
    mem_read  = rd;
    mem_write = wr;
    mem_size  = sz;
    mem_sign  = sg;
    addr      = a;
    wdata     = wd;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    set_acc(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;

    // Reset state
    step(); step();
    #1;
    chk("rst_stall",   {31'd0, stall},   32'd0);
    chk("rst_fault",   {31'd0, fault},   32'd0);
    chk("rst_req",     {31'd0, bus_req}, 32'd0);
    chk("rst_we",      {31'd0, bus_we},  32'd0);
    chk("rst_addr",    bus_addr,         32'd0);
    chk("rst_be",      {28'd0, bus_be},  32'd0);
    chk("rst_wdata",   bus_wdata,        32'd0);
    chk("rst_rdata",   rdata,            32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("idle_stall",  {31'd0, stall},   32'd0);

    // LW 0x1004, ack on third BUS cycle
    step();
    set_acc(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'h0);
    #1;
    chk("lw_c0_stall", {31'd0, stall},   32'd1);
    chk("lw_c0_req",   {31'd0, bus_req}, 32'd0);
    step(); #1;
    chk("lw_c1_stall", {31'd0, stall},   32'd1);
    chk("lw_c1_req",   {31'd0, bus_req}, 32'd1);
    chk("lw_addr",     bus_addr,         32'h0000_1004);
    chk("lw_be",       {28'd0, bus_be},  32'h0000_000F);
    chk("lw_we",       {31'd0, bus_we},  32'd0);
    step(); #1;
    chk("lw_c2_stall", {31'd0, stall},   32'd1);
    step();
    bus_ack   = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw_c3_stall", {31'd0, stall},   32'd1);
    step();
    bus_ack  = 1'b0;
    mem_read = 1'b0;
    #1;
    chk("lw_done_stall", {31'd0, stall},   32'd0);
    chk("lw_done_rdata", rdata,            32'hDEAD_BEEF);
    chk("lw_done_fault", {31'd0, fault},   32'd0);
    chk("lw_done_req",   {31'd0, bus_req}, 32'd0);

    // LB 0x2003: top lane 0x80 sign-extended
    step();
    set_acc(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0);
    #1;
    chk("lb_stall",    {31'd0, stall},   32'd1);
    step();
    bus_ack   = 1'b1;
    bus_rdata = 32'h80FF_FF00;
    #1;
    chk("lb_be",       {28'd0, bus_be},  32'h0000_0008);
    chk("lb_addr",     bus_addr,         32'h0000_2000);
    step();
    bus_ack  = 1'b0;
    mem_read = 1'b0;
    #1;
    chk("lb_rdata",    rdata,            32'hFFFF_FF80);

    // LBU 0x2003: same lane zero-extended
    step();
    set_acc(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_2003, 32'h0);
    step();
    bus_ack = 1'b1;
    #1;
    chk("lbu_be",      {28'd0, bus_be},  32'h0000_0008);
    step();
    bus_ack  = 1'b0;
    mem_read = 1'b0;
    #1;
    chk("lbu_rdata",   rdata,            32'h0000_0080);

    // SH 0x3002: upper half lanes, replicated data held while ack withheld
    step();
    set_acc(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h1234_ABCD);
    for (int i = 1; i <= 3; i++) begin
      step();
      wdata = 32'h0;
      if (i == 3) begin
        bus_ack = 1'b1;
      end
      #1;
      chk("sh_we",    {31'd0, bus_we},  32'd1);
      chk("sh_be",    {28'd0, bus_be},  32'h0000_000C);
      chk("sh_wdata", bus_wdata,        32'hABCD_ABCD);
      chk("sh_addr",  bus_addr,         32'h0000_3000);
      chk("sh_req",   {31'd0, bus_req}, 32'd1);
    end
    step();
    bus_ack   = 1'b0;
    mem_write = 1'b0;
    #1;
    chk("sh_done_stall", {31'd0, stall},   32'd0);
    chk("sh_done_req",   {31'd0, bus_req}, 32'd0);
    chk("sh_keep_rdata", rdata,            32'h0000_0080);

    // Misaligned LW 0x4002, LH 0x4001, SW 0x4003
    step();
    set_acc(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0);
    #1;
    chk("mis_lw_fault", {31'd0, fault}, 32'd1);
    chk("mis_lw_stall", {31'd0, stall}, 32'd0);
    step();
    set_acc(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_4001, 32'h0);
    #1;
    chk("mis_lw_req",   {31'd0, bus_req}, 32'd0);
    chk("mis_lh_fault", {31'd0, fault},   32'd1);
    chk("mis_lh_stall", {31'd0, stall},   32'd0);
    step();
    set_acc(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_4003, 32'h5555_5555);
    #1;
    chk("mis_lh_req",   {31'd0, bus_req}, 32'd0);
    chk("mis_sw_fault", {31'd0, fault},   32'd1);
    chk("mis_sw_stall", {31'd0, stall},   32'd0);
    step();
    set_acc(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #1;
    chk("mis_sw_req",   {31'd0, bus_req}, 32'd0);
    chk("mis_fault_end",{31'd0, fault},   32'd0);
    chk("mis_rdata",    rdata,            32'h0000_0080);

    // Timeout: no ack, bus_req high for 4 cycles then fault in DONE
    step();
    set_acc(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step(); #1;
      chk("to_req",   {31'd0, bus_req}, 32'd1);
      chk("to_stall", {31'd0, stall},   32'd1);
    end
    step();
    mem_read = 1'b0;
    #1;
    chk("to_done_req",   {31'd0, bus_req}, 32'd0);
    chk("to_done_fault", {31'd0, fault},   32'd1);
    chk("to_done_stall", {31'd0, stall},   32'd0);
    chk("to_done_rdata", rdata,            32'd0);
    step(); #1;
    chk("to_fault_once", {31'd0, fault},   32'd0);

    // Ack in the last counted cycle wins over timeout
    set_acc(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 4) begin
        bus_ack   = 1'b1;
        bus_rdata = 32'h1122_3344;
      end
      #1;
      chk("late_req", {31'd0, bus_req}, 32'd1);
    end
    step();
    bus_ack  = 1'b0;
    mem_read = 1'b0;
    #1;
    chk("late_fault", {31'd0, fault}, 32'd0);
    chk("late_rdata", rdata,          32'h1122_3344);

    // Asynchronous reset in BUS cycle 2
    step();
    set_acc(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'h0);
    step(); step();
    #1;
    chk("ar_pre_req", {31'd0, bus_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_req",   {31'd0, bus_req}, 32'd0);
    chk("ar_stall", {31'd0, stall},   32'd0);
    mem_read = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    bus_ack   = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    #1;
    chk("ar_idle_stall", {31'd0, stall}, 32'd0);
    step();
    bus_ack = 1'b0;
    #1;
    chk("ar_ack_req",   {31'd0, bus_req}, 32'd0);
    chk("ar_ack_rdata", rdata,            32'd0);
    chk("ar_ack_fault", {31'd0, fault},   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
